trace_buffer: RTL
=================

# trace_buffer

Parametrised on-chip trace capture unit for the `risc_v` core: it records retired-instruction samples (PC, instruction word, ALU result) into a circular buffer, stops on a PC-match trigger plus a programmable post-trigger window, and exposes the frozen history through an indexed read port. It replaces ad-hoc hierarchical probing of `processor.PC` / `IM_Output` / `ALU_Output` with a synthesizable, bench- and hardware-readable history.

## Interface
Parameters:
- `PC_W`, 8, PC width
- `DATA_W`, 32, instruction and result width
- `DEPTH`, 16, buffer entries; power of two, ≥ 4
- `POST_TRIG`, 4, entries captured after the trigger entry; 0 ≤ `POST_TRIG` ≤ `DEPTH`-1

Ports (`AW` = log2(`DEPTH`)):
- `CLK`  in  1  single clock, rising edge
- `RST`  in  1  synchronous, active-high reset
- `ARM`  in  1  pulse: clear and start capture
- `STOP`  in  1  pulse: manual freeze
- `VALID`  in  1  sample strobe (one retired instruction)
- `S_PC`  in  `PC_W`  sampled PC
- `S_INSTR`  in  `DATA_W`  sampled instruction
- `S_RES`  in  `DATA_W`  sampled ALU result
- `TRIG_EN`  in  1  enable PC-match trigger
- `TRIG_PC`  in  `PC_W`  trigger PC
- `RD_IDX`  in  `AW`  read index, 0 = oldest entry
- `RD_DATA`  out  `PC_W`+2·`DATA_W`  {PC, INSTR, RES} at `RD_IDX`
- `STATE`  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
- `COUNT`  out  `AW`+1  valid entries, saturates at `DEPTH`
- `OVERFLOW`  out  1  at least one entry overwritten since ARM
- `TRIGGERED`  out  1  trigger has fired since ARM
- `TRIG_POS`  out  `AW`  index (relative to oldest) of trigger entry; valid in DONE when `TRIGGERED`=1

## Operation
- Priority per cycle: `RST` > `ARM` > `STOP` > capture.
- `RST`: `STATE`=IDLE; write pointer, `COUNT`, `OVERFLOW`, `TRIGGERED`, `TRIG_POS`, post counter = 0; `RD_DATA`=0. RAM contents not cleared.
- `ARM` in any state: pointer/`COUNT`/flags cleared, → ARMED; the sample presented in the `ARM` cycle is not written.
- `STOP` in ARMED/POST: → DONE, no write that cycle. Ignored in IDLE/DONE.
- IDLE, DONE: `VALID` ignored, buffer frozen.
- ARMED, `VALID`=1: write {`S_PC`,`S_INSTR`,`S_RES`} at pointer; pointer += 1 mod `DEPTH`; `COUNT` += 1 up to `DEPTH`; a write when `COUNT`=`DEPTH` sets `OVERFLOW`.
- Trigger: ARMED ∧ `VALID` ∧ `TRIG_EN` ∧ `S_PC`==`TRIG_PC`. The matching sample is written; its physical slot is latched; `TRIGGERED`=1; → POST with post counter = `POST_TRIG`, or → DONE directly if `POST_TRIG`=0.
- POST, `VALID`=1: write as in ARMED, post counter −1; the write that takes it to 0 → DONE. Further matches in POST are ignored.
- `VALID`=0 cycles never write, count, or decrement.
- Oldest slot = 0 while `COUNT` < `DEPTH`, else the write pointer.
- `TRIG_POS` = (trigger slot − oldest slot) mod `DEPTH`, updated on every write while `TRIGGERED`=1, and final in DONE.
- Read: physical slot = (oldest + `RD_IDX`) mod `DEPTH`. `RD_DATA` = 0 if `RD_IDX` ≥ `COUNT`. Legal in every state; it reflects live contents during capture.

## Timing
- All outputs are registered. `STATE`, `COUNT`, flags, and `TRIG_POS` reflect an edge's event immediately after that edge.
- `RD_DATA` latency is 1 cycle: `RD_IDX` sampled at edge N drives `RD_DATA` after edge N, using the pointer/count state held before edge N.
- The trigger compare uses same-cycle inputs, so there is zero-cycle trigger latency. DONE is entered at the edge of the `POST_TRIG`-th post-trigger write.
- `ARM` and `STOP` are levels sampled each edge. Holding `ARM` keeps the block cleared in ARMED.
- `RST` mid-POST: IDLE at the next edge, all counters 0.

## Test plan
- Reset: assert `RST` 2 cycles → `STATE`=0, `COUNT`=0, `OVERFLOW`=`TRIGGERED`=0, `RD_DATA`=0.
- No wrap (`DEPTH`=8): `ARM`, 5 `VALID` samples with PC 0..4, `STOP` → `STATE`=3, `COUNT`=5; `RD_IDX` 0..4 gives PC 0..4; `RD_IDX`=5 gives 0.
- Wrap: `ARM`, 12 samples with PC 0..11, `STOP` → `COUNT`=8, `OVERFLOW`=1; idx0 PC=4, idx7 PC=11.
- Trigger (`DEPTH`=8, `POST_TRIG`=3, `TRIG_PC`=6): samples PC 0..20 with `VALID` low every 3rd cycle → DONE after PC 9 is written; PC 10+ not stored; idx0 PC=2; `TRIG_POS`=4 (PC 6); idx7 PC=9.
- `POST_TRIG`=0, `TRIG_PC`=3: samples PC 0..5 → DONE on the PC 3 write; `COUNT`=4, `TRIG_POS`=3.
- Collisions: `ARM`+`VALID` in DONE → ARMED, `COUNT`=0 (sample dropped); `ARM`+`STOP` → ARMED; `RST` during POST → IDLE, `COUNT`=0, `TRIGGERED`=0.

Source files
------------

// File: rtl/trace_buffer.sv
// Trace capture unit: records {PC, INSTR, RES} samples into a circular buffer,
// freezes on a PC-match trigger plus post-trigger window, and serves indexed reads.
module trace_buffer #(
  parameter int unsigned PC_W      = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 4,
  localparam int unsigned AW       = $clog2(DEPTH),
  localparam int unsigned EW       = PC_W + 2 * DATA_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ARM,
  input  logic              STOP,
  input  logic              VALID,
  input  logic [PC_W-1:0]   S_PC,
  input  logic [DATA_W-1:0] S_INSTR,
  input  logic [DATA_W-1:0] S_RES,
  input  logic              TRIG_EN,
  input  logic [PC_W-1:0]   TRIG_PC,
  input  logic [AW-1:0]     RD_IDX,
  output logic [EW-1:0]     RD_DATA,
  output logic [1:0]        STATE,
  output logic [AW:0]       COUNT,
  output logic              OVERFLOW,
  output logic              TRIGGERED,
  output logic [AW-1:0]     TRIG_POS
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] POST_LOAD = AW'(POST_TRIG);

  logic [EW-1:0] mem [DEPTH];

  state_t        state, state_next;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          overflow;
  logic          triggered;
  logic [AW-1:0] trig_slot;
  logic [AW-1:0] trig_pos;
  logic [AW-1:0] post_cnt;

  logic          clear;
  logic          do_write;
  logic          trig_hit;
  logic [AW-1:0] ptr_inc;
  logic [AW:0]   count_inc;
  logic [AW-1:0] oldest_after;
  logic [AW-1:0] slot_after;
  logic [AW-1:0] oldest_now;
  logic [AW-1:0] rd_slot;
  logic          rd_in_range;

  always_comb begin
    state_next = state;
    clear      = 1'b0;
    do_write   = 1'b0;
    trig_hit   = 1'b0;
    if (ARM) begin
      clear      = 1'b1;
      state_next = ARMED;
    end else if (STOP && (state == ARMED || state == POST)) begin
      state_next = DONE;
    end else if (VALID && state == ARMED) begin
      do_write = 1'b1;
      if (TRIG_EN && S_PC == TRIG_PC) begin
        trig_hit   = 1'b1;
        state_next = (POST_TRIG == 0) ? DONE : POST;
      end
    end else if (VALID && state == POST) begin
      do_write = 1'b1;
      if (post_cnt == AW'(1)) state_next = DONE;
    end
  end

  // Post-write geometry: TRIG_POS is recomputed relative to the oldest slot
  // as it will be after this write, so it stays correct while wrapping.
  always_comb begin
    ptr_inc      = wr_ptr + AW'(1);
    count_inc    = (count == FULL) ? count : count + (AW+1)'(1);
    oldest_after = (count_inc == FULL) ? ptr_inc : '0;
    slot_after   = trig_hit ? wr_ptr : trig_slot;
    oldest_now   = (count == FULL) ? wr_ptr : '0;
    rd_slot      = oldest_now + RD_IDX;
    rd_in_range  = ({1'b0, RD_IDX} < count);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      triggered <= 1'b0;
      trig_slot <= '0;
      trig_pos  <= '0;
      post_cnt  <= '0;
    end else begin
      state <= state_next;
      if (clear) begin
        wr_ptr    <= '0;
        count     <= '0;
        overflow  <= 1'b0;
        triggered <= 1'b0;
        trig_slot <= '0;
        trig_pos  <= '0;
        post_cnt  <= '0;
      end else if (do_write) begin
        wr_ptr <= ptr_inc;
        count  <= count_inc;
        if (count == FULL) overflow <= 1'b1;
        if (trig_hit) begin
          triggered <= 1'b1;
          trig_slot <= wr_ptr;
          post_cnt  <= POST_LOAD;
        end else if (state == POST) begin
          post_cnt <= post_cnt - AW'(1);
        end
        if (trig_hit || triggered) trig_pos <= slot_after - oldest_after;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && do_write) mem[wr_ptr] <= {S_PC, S_INSTR, S_RES};
  end

  // Read uses pre-edge pointer/count, giving one cycle of latency.
  always_ff @(posedge CLK) begin
    if (RST)              RD_DATA <= '0;
    else if (rd_in_range) RD_DATA <= mem[rd_slot];
    else                  RD_DATA <= '0;
  end

  assign STATE     = state;
  assign COUNT     = count;
  assign OVERFLOW  = overflow;
  assign TRIGGERED = triggered;
  assign TRIG_POS  = trig_pos;

endmodule
